// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor: bimodal + gshare tables arbitrated by a PC-indexed chooser.
// Tables self-initialise after reset; prediction is combinational, training happens on resolved updates.
module branch_predict_tournament #(
    parameter int AWIDTH = 10,
    parameter int HWIDTH = 8,
    parameter int CBITS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_cur,
    output logic        taken,
    output logic        ready,
    input  logic [31:0] inst_last,
    input  logic        taken_last,
    input  logic        update_valid,
    output logic [31:0] hit_count,
    output logic [31:0] branch_count
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int MSB   = CBITS - 1;
    localparam logic [CBITS-1:0] CTR_INIT = {1'b0, {(CBITS-1){1'b1}}};
    localparam logic [CBITS-1:0] CTR_MAX  = '1;
    localparam logic [1:0]       CHO_INIT = 2'b01;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state, state_nxt;
    logic [AWIDTH-1:0]   ptr;
    logic [HWIDTH-1:0]   ghr;
    logic [AWIDTH-1:0]   ghr_ext;

    logic [CBITS-1:0]    bim_tab [DEPTH];
    logic [CBITS-1:0]    gsh_tab [DEPTH];
    logic [1:0]          cho_tab [DEPTH];

    logic [AWIDTH-1:0]   pidx_a, gidx_a, pidx_b, gidx_b;
    logic [CBITS-1:0]    bim_a, gsh_a, bim_b, gsh_b;
    logic [1:0]          cho_a, cho_b;
    logic                final_a, final_b, hit_b;

    logic [CBITS-1:0]    bim_upd, gsh_upd;
    logic [1:0]          cho_upd;

    logic                upd_fire, tab_we;
    logic [AWIDTH-1:0]   bim_waddr, gsh_waddr, cho_waddr;
    logic [CBITS-1:0]    bim_wdata, gsh_wdata;
    logic [1:0]          cho_wdata;

    // PC bits outside the index field never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{inst_cur[31:AWIDTH+2], inst_cur[1:0],
                              inst_last[31:AWIDTH+2], inst_last[1:0]};

    assign ghr_ext = AWIDTH'(ghr);

    // Port A: prediction side.
    assign pidx_a  = inst_cur[AWIDTH+1:2];
    assign gidx_a  = pidx_a ^ ghr_ext;
    assign bim_a   = bim_tab[pidx_a];
    assign gsh_a   = gsh_tab[gidx_a];
    assign cho_a   = cho_tab[pidx_a];
    assign final_a = cho_a[1] ? gsh_a[MSB] : bim_a[MSB];
    assign taken   = ready & final_a;

    // Port B: update side, also the write address.
    assign pidx_b  = inst_last[AWIDTH+1:2];
    assign gidx_b  = pidx_b ^ ghr_ext;
    assign bim_b   = bim_tab[pidx_b];
    assign gsh_b   = gsh_tab[gidx_b];
    assign cho_b   = cho_tab[pidx_b];
    assign final_b = cho_b[1] ? gsh_b[MSB] : bim_b[MSB];
    assign hit_b   = (final_b == taken_last);

    function automatic logic [CBITS-1:0] sat_step(input logic [CBITS-1:0] v, input logic up);
        if (up) return (v == CTR_MAX) ? v : v + CBITS'(1);
        return (v == '0) ? v : v - CBITS'(1);
    endfunction

    assign bim_upd = sat_step(bim_b, taken_last);
    assign gsh_upd = sat_step(gsh_b, taken_last);

    // Chooser only learns when the two components disagree.
    always_comb begin
        cho_upd = cho_b;
        if (bim_b[MSB] != gsh_b[MSB]) begin
            if (gsh_b[MSB] == taken_last) cho_upd = (cho_b == 2'b11) ? cho_b : cho_b + 2'd1;
            else                          cho_upd = (cho_b == 2'b00) ? cho_b : cho_b - 2'd1;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = state;
        ready     = 1'b0;
        upd_fire  = 1'b0;
        tab_we    = 1'b0;
        bim_waddr = pidx_b;
        gsh_waddr = gidx_b;
        cho_waddr = pidx_b;
        bim_wdata = bim_upd;
        gsh_wdata = gsh_upd;
        cho_wdata = cho_upd;
        case (state)
            ST_INIT: begin
                tab_we    = 1'b1;
                bim_waddr = ptr;
                gsh_waddr = ptr;
                cho_waddr = ptr;
                bim_wdata = CTR_INIT;
                gsh_wdata = CTR_INIT;
                cho_wdata = CHO_INIT;
                if (ptr == '1) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                ready    = 1'b1;
                upd_fire = update_valid;
                tab_we   = update_valid;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_INIT;
            ptr          <= '0;
            ghr          <= '0;
            hit_count    <= '0;
            branch_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) ptr <= ptr + AWIDTH'(1);
            if (upd_fire) begin
                ghr          <= {ghr[HWIDTH-2:0], taken_last};
                branch_count <= branch_count + 32'd1;
                if (hit_b) hit_count <= hit_count + 32'd1;
            end
        end
    end

    // NOTE: the tables have no reset port; the INIT sweep rewrites every entry instead.
    always_ff @(posedge clk) begin
        if (rst && tab_we) begin
            bim_tab[bim_waddr] <= bim_wdata;
            gsh_tab[gsh_waddr] <= gsh_wdata;
            cho_tab[cho_waddr] <= cho_wdata;
        end
    end

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Self-checking bench for branch_predict_tournament (AWIDTH=4) against a table-level
// behavioural model driven with directed and $urandom stimulus.
module tb_branch_predict_tournament;

    localparam int AW    = 4;
    localparam int HW    = 4;
    localparam int CB    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int HALF  = 1 << (CB - 1);
    localparam int CMAX  = (1 << CB) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_cur = '0;
    logic        taken;
    logic        ready;
    logic [31:0] inst_last = '0;
    logic        taken_last = 1'b0;
    logic        update_valid = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] branch_count;

    int tests_run    = 0;
    int tests_failed = 0;

    branch_predict_tournament #(.AWIDTH(AW), .HWIDTH(HW), .CBITS(CB)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_cur     (inst_cur),
        .taken        (taken),
        .ready        (ready),
        .inst_last    (inst_last),
        .taken_last   (taken_last),
        .update_valid (update_valid),
        .hit_count    (hit_count),
        .branch_count (branch_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: counters held as plain integers, MSB test done as ">= HALF".
    int          m_bim [DEPTH];
    int          m_gsh [DEPTH];
    int          m_cho [DEPTH];
    int          m_ghr;
    logic [31:0] m_hit, m_branch;
    bit          m_ready;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int i = m_idx(pc);
        if (!m_ready) return 1'b0;
        if (m_cho[i] >= 2) return m_gsh[i ^ m_ghr] >= HALF;
        return m_bim[i] >= HALF;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_bim[i] = HALF - 1;
            m_gsh[i] = HALF - 1;
            m_cho[i] = 1;
        end
        m_ghr = 0; m_hit = '0; m_branch = '0; m_ready = 1'b0;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit t);
        int  i, g;
        bit  bp, gp, fp;
        if (!m_ready) return;
        i  = m_idx(pc);
        g  = i ^ m_ghr;
        bp = m_bim[i] >= HALF;
        gp = m_gsh[g] >= HALF;
        fp = (m_cho[i] >= 2) ? gp : bp;
        if (fp == t) m_hit = m_hit + 1;
        m_branch = m_branch + 1;
        m_bim[i] = t ? ((m_bim[i] + 1 > CMAX) ? CMAX : m_bim[i] + 1) : ((m_bim[i] > 0) ? m_bim[i] - 1 : 0);
        m_gsh[g] = t ? ((m_gsh[g] + 1 > CMAX) ? CMAX : m_gsh[g] + 1) : ((m_gsh[g] > 0) ? m_gsh[g] - 1 : 0);
        if (bp != gp) begin
            if (gp == t) m_cho[i] = (m_cho[i] < 3) ? m_cho[i] + 1 : 3;
            else         m_cho[i] = (m_cho[i] > 0) ? m_cho[i] - 1 : 0;
        end
        m_ghr = (m_ghr * 2 + int'(t)) % (1 << HW);
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc_l, input bit t, input logic [31:0] pc_c);
        update_valid = v;
        inst_last    = pc_l;
        taken_last   = t;
        inst_cur     = pc_c;
    endtask

    // One clock; the model sees the same update the DUT consumed at this edge.
    task automatic tick();
        bit          v  = update_valid;
        logic [31:0] pl = inst_last;
        bit          t  = taken_last;
        @(posedge clk);
        #1;
        if (v) m_update(pl, t);
        update_valid = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        update_valid = 1'b0;
        rst = 1'b0;
        repeat (n) tick();
        model_reset();
        rst = 1'b1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        if (ready === 1'b1) m_ready = 1'b1;
    endtask

    task automatic test_reset();
        int cycles = 0;
        int bad_taken = 0;
        apply_reset(2);
        tests_run++;
        if (ready !== 1'b0 || hit_count !== 32'd0 || branch_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%0b hit=%0d branch=%0d required ready=0 hit=0 branch=0",
                     ready, hit_count, branch_count);
        end
        while (ready !== 1'b1 && cycles < 200) begin
            inst_cur = $urandom;
            #1;
            if (taken !== 1'b0) bad_taken++;
            tick();
            cycles++;
        end
        if (ready === 1'b1) m_ready = 1'b1;
        tests_run++;
        if (cycles !== DEPTH) begin
            tests_failed++;
            $display("FAIL init_length: ready low for %0d cycles, required %0d", cycles, DEPTH);
        end
        tests_run++;
        if (bad_taken !== 0) begin
            tests_failed++;
            $display("FAIL init_taken: taken high on %0d init cycles, required 0", bad_taken);
        end
    endtask

    task automatic test_bimodal_training();
        logic [1:0] exp_seq [6] = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        bit         dir_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h40, dir_seq[i], 32'h40);
            tick();
            tests_run++;
            if (dut.bim_tab[0] !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL bimodal_entry step %0d: entry=%b required %b", i, dut.bim_tab[0], exp_seq[i]);
            end
            if (i == 0) begin
                tests_run++;
                if (dut.cho_tab[0] !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL chooser_agree: chooser=%b required 01", dut.cho_tab[0]);
                end
            end
            if (i == 2) begin
                tests_run++;
                if (taken !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bimodal_predict: taken=%0b required 1", taken);
                end
            end
        end
    endtask

    task automatic test_update_during_init();
        int cycles = 0;
        int bad = 0;
        apply_reset(1);
        while (ready !== 1'b1 && cycles < 200) begin
            drive(cycles % 2 == 0, $urandom, 1'b1, 32'h0);
            tick();
            cycles++;
        end
        if (ready === 1'b1) m_ready = 1'b1;
        tests_run++;
        if (ready !== 1'b1 || branch_count !== 32'd0 || hit_count !== 32'd0 || dut.ghr !== '0) begin
            tests_failed++;
            $display("FAIL init_update_ignored: ready=%0b branch=%0d hit=%0d ghr=%0h required 1/0/0/0",
                     ready, branch_count, hit_count, dut.ghr);
        end
        for (int i = 0; i < DEPTH; i++) begin
            inst_cur = 32'(i) << 2;
            #1;
            if (taken !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL init_update_predict: %0d entries predict taken, required 0", bad);
        end
    endtask

    task automatic test_alternating();
        int          cycles;
        logic [31:0] prev;
        apply_reset(1);
        wait_ready(cycles);
        for (int i = 0; i < 40; i++) begin
            prev = hit_count;
            drive(1'b1, 32'h100, (i % 2) == 0, 32'h100);
            tick();
            if (i >= 30) begin
                tests_run++;
                if (hit_count !== prev + 32'd1) begin
                    tests_failed++;
                    $display("FAIL alt_hit update %0d: hit=%0d required %0d", i, hit_count, prev + 32'd1);
                end
            end
        end
        tests_run++;
        if (dut.cho_tab[0] < 2'd2) begin
            tests_failed++;
            $display("FAIL alt_chooser: chooser=%0d required >=2", dut.cho_tab[0]);
        end
        tests_run++;
        if (branch_count !== 32'd40 || hit_count !== m_hit) begin
            tests_failed++;
            $display("FAIL alt_counts: branch=%0d hit=%0d required 40 and %0d", branch_count, hit_count, m_hit);
        end
    endtask

    task automatic test_stats_gating();
        int cycles;
        apply_reset(1);
        wait_ready(cycles);
        for (int i = 0; i < 10; i++) begin
            drive(i % 2 == 0, $urandom, 1'($urandom_range(0, 1)), $urandom);
            tick();
            tests_run++;
            if (dut.ghr !== HW'(m_ghr)) begin
                tests_failed++;
                $display("FAIL gating_ghr cycle %0d: ghr=%0h required %0h", i, dut.ghr, HW'(m_ghr));
            end
        end
        tests_run++;
        if (branch_count !== 32'd5 || hit_count !== m_hit) begin
            tests_failed++;
            $display("FAIL gating_counts: branch=%0d hit=%0d required 5 and %0d", branch_count, hit_count, m_hit);
        end
    endtask

    task automatic test_back_to_back_random();
        int          bad = 0;
        logic [31:0] pl, pc;
        bit          exp_t;
        for (int i = 0; i < 400; i++) begin
            pl = $urandom;
            pc = ($urandom_range(0, 3) == 0) ? pl : $urandom;
            drive($urandom_range(0, 3) != 0, pl, 1'($urandom_range(0, 1)), pc);
            #1;
            exp_t = m_pred(pc);
            if (taken !== exp_t) begin
                bad++;
                if (bad <= 5) $display("FAIL random_pred cycle %0d: taken=%0b required %0b", i, taken, exp_t);
            end
            tick();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL random_pred_total: %0d wrong predictions, required 0", bad);
        end
        tests_run++;
        if (hit_count !== m_hit || branch_count !== m_branch || dut.ghr !== HW'(m_ghr)) begin
            tests_failed++;
            $display("FAIL random_state: hit=%0d branch=%0d ghr=%0h required %0d %0d %0h",
                     hit_count, branch_count, dut.ghr, m_hit, m_branch, HW'(m_ghr));
        end
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        apply_reset(1);
        wait_ready(cycles);
        repeat (3) begin
            drive(1'b1, 32'h40, 1'b1, 32'h40);
            tick();
        end
        inst_cur = 32'h40;
        #1;
        tests_run++;
        if (taken !== 1'b1 || taken !== m_pred(32'h40)) begin
            tests_failed++;
            $display("FAIL midrun_trained: taken=%0b required 1", taken);
        end
        apply_reset(1);
        tests_run++;
        if (hit_count !== 32'd0 || branch_count !== 32'd0 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: hit=%0d branch=%0d ready=%0b required 0 0 0",
                     hit_count, branch_count, ready);
        end
        wait_ready(cycles);
        tests_run++;
        if (cycles !== DEPTH) begin
            tests_failed++;
            $display("FAIL midrun_init_length: %0d cycles, required %0d", cycles, DEPTH);
        end
        inst_cur = 32'h40;
        #1;
        tests_run++;
        if (taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_retrained: taken=%0b required 0", taken);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bimodal_training();
        test_alternating();
        test_stats_gating();
        test_back_to_back_random();
        test_update_during_init();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
